apb_slave_regfile: RTL and testbench

APB completer holding a small bank of 8-bit read/write registers. It answers the team's 8-bit-address, 8-bit-data APB initiator, inserts a programmable number of wait states, and exposes register 0 as a control output to downstream logic. Out-of-range accesses are harmless and can optionally be flagged with PSLVERR.

---
 rtl/apb_slave_regfile.sv | 141 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a bank of 8-bit registers, programmable wait states and reg 0 as ctrl_out.
// Define APB_SLV_PSLVERR_EN to add the registered PSLVERR response for addresses >= NUM_REGS.
module apb_slave_regfile #(
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       PSELx,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
`ifdef APB_SLV_PSLVERR_EN
   output logic       PSLVERR,
`endif
   output logic [7:0] ctrl_out
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   logic [1:0] state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic       wr_q, wr_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ready_q, ready_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
`ifdef APB_SLV_PSLVERR_EN
   logic       err_q, err_d;
`endif

   logic       go_ready;
   logic       in_range;
   logic       lk_wr;
   logic [7:0] lk_addr;
   logic [7:0] rd_val;

   // With zero wait states READY is entered on the setup edge, so the lookup must use the live bus.
   assign lk_addr  = (state_q == ST_IDLE) ? PADDR : addr_q;
   assign lk_wr    = (state_q == ST_IDLE) ? PWRITE : wr_q;
   assign in_range = {1'b0, lk_addr} < 9'(NUM_REGS);

   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NUM_REGS; i++)
         if (lk_addr == 8'(i)) rd_val = regs_q[i];
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      rdata_d  = rdata_q;
      regs_d   = regs_q;
      go_ready = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
      err_d    = err_q;
`endif
      if (state_q == ST_IDLE) begin
         if (PSELx && !PENABLE) begin
            addr_d   = PADDR;
            wr_d     = PWRITE;
            cnt_d    = CNT_INIT;
            go_ready = (WAIT_CYCLES == 0);
            state_d  = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
         end
      end else if (!PSELx) begin
         state_d = ST_IDLE;
         ready_d = 1'b0;
         rdata_d = 8'h00;
`ifdef APB_SLV_PSLVERR_EN
         err_d   = 1'b0;
`endif
      end else if (state_q == ST_WAIT) begin
         if (PENABLE) begin
            cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
            if (cnt_q <= 4'd1) begin
               state_d  = ST_READY;
               go_ready = 1'b1;
            end
         end
      end else if (PENABLE && ready_q) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_q && addr_q == 8'(i)) regs_d[i] = PWDATA;
         state_d = ST_IDLE;
         ready_d = 1'b0;
         rdata_d = 8'h00;
`ifdef APB_SLV_PSLVERR_EN
         err_d   = 1'b0;
`endif
      end
      if (go_ready) begin
         ready_d = 1'b1;
         rdata_d = (lk_wr || !in_range) ? 8'h00 : rd_val;
`ifdef APB_SLV_PSLVERR_EN
         err_d   = !in_range;
`endif
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         addr_q  <= 8'h00;
         wr_q    <= 1'b0;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         rdata_q <= 8'h00;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
`ifdef APB_SLV_PSLVERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         regs_q  <= regs_d;
`ifdef APB_SLV_PSLVERR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign PRDATA   = rdata_q;
   assign PREADY   = ready_q;
   assign ctrl_out = regs_q[0];
`ifdef APB_SLV_PSLVERR_EN
   assign PSLVERR  = err_q;
`endif
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed bench over four instances with WAIT_CYCLES 1, 0, 3 and 2.
module tb_apb_slave_regfile;
   localparam int W [4] = '{1, 0, 3, 2};

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [3:0] psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata [4];
   logic [3:0] pready;
   logic [7:0] ctrl [4];
   logic [3:0] slverr;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(W[g])) u_dut (
         .PCLK     (PCLK),
         .PRESETn  (PRESETn),
         .PSELx    (psel[g]),
         .PENABLE  (penable),
         .PWRITE   (pwrite),
         .PADDR    (paddr),
         .PWDATA   (pwdata),
         .PRDATA   (prdata[g]),
         .PREADY   (pready[g]),
`ifdef APB_SLV_PSLVERR_EN
         .PSLVERR  (slverr[g]),
`endif
         .ctrl_out (ctrl[g])
      );
`ifndef APB_SLV_PSLVERR_EN
      assign slverr[g] = 1'b0;
`endif
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Returns at the negedge right after the completion edge; n counts access cycles up to PREADY.
   task automatic xfer(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output int n, output logic [7:0] cd, output logic er);
      @(negedge PCLK);
      psel = 4'(1) << i; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(negedge PCLK);
      penable = 1'b1; paddr = ~a; pwrite = ~wr; n = 1;
      while (!pready[i] && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      rd = prdata[i]; cd = ctrl[i]; er = slverr[i];
      @(negedge PCLK);
      psel = 4'b0; penable = 1'b0;
   endtask

   task automatic abort_wr(input int i, input logic [7:0] a, input logic [7:0] d, output logic rdy_a1);
      @(negedge PCLK);
      psel = 4'(1) << i; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge PCLK);
      psel = 4'b0; rdy_a1 = pready[i];
      @(negedge PCLK);
   endtask

   initial begin
      logic [7:0] rd, cd;
      logic       er, r1;
      int         n;
      PRESETn = 1'b0; psel = 4'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
      repeat (2) @(negedge PCLK);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_prdata%0d", k), 32'(prdata[k]), 32'h00);
         check($sformatf("rst_pready%0d", k), 32'(pready[k]), 32'h0);
         check($sformatf("rst_ctrl%0d", k), 32'(ctrl[k]), 32'h00);
      end
      PRESETn = 1'b1;
      for (int a = 0; a < 16; a++) begin
         xfer(0, 1'b0, 8'(a), 8'h00, rd, n, cd, er);
         check($sformatf("rst_read%0d", a), 32'(rd), 32'h00);
      end
      xfer(0, 1'b1, 8'h03, 8'hA5, rd, n, cd, er);
      check("w1_write_len", 32'(n), 32'd2);
      xfer(0, 1'b0, 8'h03, 8'h00, rd, n, cd, er);
      check("w1_read_len", 32'(n), 32'd2);
      check("w1_read_data", 32'(rd), 32'hA5);
      check("post_pready", 32'(pready[0]), 32'h0);
      check("post_prdata", 32'(prdata[0]), 32'h00);
      xfer(0, 1'b1, 8'h00, 8'h3C, rd, n, cd, er);
      check("ctrl_at_done", 32'(cd), 32'h00);
      check("ctrl_after", 32'(ctrl[0]), 32'h3C);
      xfer(1, 1'b1, 8'h03, 8'hA5, rd, n, cd, er);
      check("w0_write_len", 32'(n), 32'd1);
      xfer(1, 1'b0, 8'h03, 8'h00, rd, n, cd, er);
      check("w0_read_len", 32'(n), 32'd1);
      check("w0_read_data", 32'(rd), 32'hA5);
      xfer(2, 1'b1, 8'h03, 8'h5A, rd, n, cd, er);
      check("w3_write_len", 32'(n), 32'd4);
      xfer(2, 1'b0, 8'h03, 8'h00, rd, n, cd, er);
      check("w3_read_len", 32'(n), 32'd4);
      check("w3_read_data", 32'(rd), 32'h5A);
      xfer(0, 1'b1, 8'h20, 8'h77, rd, n, cd, er);
`ifdef APB_SLV_PSLVERR_EN
      check("oor_write_err", 32'(er), 32'h1);
`endif
      xfer(0, 1'b0, 8'h20, 8'h00, rd, n, cd, er);
      check("oor_read_data", 32'(rd), 32'h00);
`ifdef APB_SLV_PSLVERR_EN
      check("oor_read_err", 32'(er), 32'h1);
      check("oor_err_clear", 32'(slverr[0]), 32'h0);
`endif
      xfer(0, 1'b0, 8'h00, 8'h00, rd, n, cd, er);
      check("oor_no_alias", 32'(rd), 32'h3C);
      check("oor_ctrl", 32'(ctrl[0]), 32'h3C);
`ifdef APB_SLV_PSLVERR_EN
      check("inr_read_err", 32'(er), 32'h0);
`endif
      @(negedge PCLK);
      psel = 4'b0001; penable = 1'b1; pwrite = 1'b0; paddr = 8'h03;
      repeat (2) begin
         @(negedge PCLK);
         check("no_setup_pready", 32'(pready[0]), 32'h0);
      end
      psel = 4'b0; penable = 1'b0;
      xfer(3, 1'b1, 8'h05, 8'h22, rd, n, cd, er);
      check("w2_write_len", 32'(n), 32'd3);
      abort_wr(3, 8'h05, 8'h11, r1);
      check("abort_w2_a1", 32'(r1), 32'h0);
      check("abort_w2_pready", 32'(pready[3]), 32'h0);
      xfer(3, 1'b0, 8'h05, 8'h00, rd, n, cd, er);
      check("abort_w2_len", 32'(n), 32'd3);
      check("abort_w2_data", 32'(rd), 32'h22);
      abort_wr(1, 8'h03, 8'h11, r1);
      check("abort_w0_a1", 32'(r1), 32'h1);
      check("abort_w0_pready", 32'(pready[1]), 32'h0);
      check("abort_w0_prdata", 32'(prdata[1]), 32'h00);
      xfer(1, 1'b0, 8'h03, 8'h00, rd, n, cd, er);
      check("abort_w0_data", 32'(rd), 32'hA5);
      @(negedge PCLK);
      psel = 4'b0001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'h99;
      @(negedge PCLK);
      penable = 1'b1;
      PRESETn = 1'b0;
      @(negedge PCLK);
      psel = 4'b0; penable = 1'b0;
      PRESETn = 1'b1;
      check("midrst_pready", 32'(pready[0]), 32'h0);
      check("midrst_ctrl", 32'(ctrl[0]), 32'h00);
      xfer(0, 1'b0, 8'h07, 8'h00, rd, n, cd, er);
      check("midrst_read", 32'(rd), 32'h00);
      check("midrst_len", 32'(n), 32'd2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
